// File: rtl/hrm_pkg.sv
// Shared definitions for the little-man style machine: data word type, default
// FIFO geometry and the opcode encoding used by the control unit.
package hrm_pkg;

    localparam int HRM_WIDTH      = 8;
    localparam int HRM_DEPTH_LOG2 = 5;

    typedef logic [HRM_WIDTH-1:0] hrm_word_t;

    typedef enum logic [3:0] {
        OP_INBOX    = 4'h0,
        OP_OUTBOX   = 4'h1,
        OP_COPYFROM = 4'h2,
        OP_COPYTO   = 4'h3,
        OP_ADD      = 4'h4,
        OP_SUB      = 4'h5,
        OP_BUMPUP   = 4'h6,
        OP_BUMPDN   = 4'h7,
        OP_JUMP     = 4'h8,
        OP_JUMPZ    = 4'h9,
        OP_JUMPN    = 4'hA
    } hrm_opcode_t;

    function automatic logic is_outbox_op(input hrm_opcode_t op);
        return op == OP_OUTBOX;
    endfunction

endpackage

// File: rtl/ram_dp_async.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read
// port. Contents are never reset.
module ram_dp_async #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/outbox.sv
// Show-ahead output FIFO fed by the control unit's OUTBOX strobe.
// Optional same-cycle empty bypass is enabled by defining OUTBOX_BYPASS_EN.
module outbox
    import hrm_pkg::*;
#(
    parameter int WIDTH      = HRM_WIDTH,
    parameter int DEPTH_LOG2 = HRM_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  wO,
    input  logic [WIDTH-1:0]      i_data,
    output logic                  outFull,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overflow
);

    // Handshake: a word leaves on a rising edge where o_valid and i_ready are
    // both high; o_data is held steady while o_valid is high and i_ready low.

    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                empty;
    logic                bypass;
    logic                push_en;
    logic                pop_en;
    logic [WIDTH-1:0]    ram_rdata;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign outFull = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign o_count = wr_ptr - rd_ptr;

`ifdef OUTBOX_BYPASS_EN
    assign bypass = empty & wO & i_ready;
`else
    assign bypass = 1'b0;
`endif

    assign o_valid = ~empty | bypass;
    assign o_data  = bypass ? i_data : ram_rdata;

    // Fullness is judged before the edge, so a pop does not make room for a
    // push in the same cycle.
    assign push_en = wO & ~outFull & ~bypass;
    assign pop_en  = ~empty & i_ready;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wO & outFull) begin
                o_overflow <= 1'b1;
            end
        end
    end

    ram_dp_async #(
        .WIDTH  (WIDTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (push_en & ~i_rst),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (i_data),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_outbox.sv
// Directed plus random bench for outbox with a queue-based reference model.
// Build with OUTBOX_BYPASS_EN defined to exercise the empty bypass path.
module tb_outbox;
    import hrm_pkg::*;

    localparam int WIDTH      = 8;
    localparam int DEPTH_LOG2 = 5;
    localparam int DEPTH      = 2**DEPTH_LOG2;
`ifdef OUTBOX_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                clk;
    logic                i_rst;
    logic                wO;
    logic [WIDTH-1:0]    i_data;
    logic                outFull;
    logic [WIDTH-1:0]    o_data;
    logic                o_valid;
    logic                i_ready;
    logic [DEPTH_LOG2:0] o_count;
    logic                o_overflow;

    outbox #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .wO         (wO),
        .i_data     (i_data),
        .outFull    (outFull),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_count    (o_count),
        .o_overflow (o_overflow)
    );

    // Clock and initial input levels
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    logic [WIDTH-1:0] exp_q[$];
    int               model_count;
    logic             model_ovf;
    int               checks;
    int               errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus. Inputs change on the falling edge; outputs are
    // compared against the model before the rising edge, then the model advances.
    task automatic cycle(input logic wo, input logic [WIDTH-1:0] d, input logic rdy);
        int  pre_count;
        bit  took_bypass;
        @(negedge clk);
        wO      = wo;
        i_data  = d;
        i_ready = rdy;
        #1;
        pre_count   = model_count;
        took_bypass = 1'b0;
        chk("o_count", 32'(o_count), 32'(pre_count));
        chk("outFull", 32'(outFull), 32'(pre_count == DEPTH));
        chk("o_overflow", 32'(o_overflow), 32'(model_ovf));
        if (pre_count > 0) begin
            chk("o_valid", 32'(o_valid), 32'd1);
            chk("o_data_head", 32'(o_data), 32'(exp_q[0]));
            if (rdy) begin
                void'(exp_q.pop_front());
                model_count--;
            end
        end else if (BYPASS && wo && rdy) begin
            chk("bypass_valid", 32'(o_valid), 32'd1);
            chk("bypass_data", 32'(o_data), 32'(d));
            took_bypass = 1'b1;
        end else begin
            chk("o_valid_empty", 32'(o_valid), 32'd0);
        end
        if (wo && !took_bypass) begin
            if (pre_count >= DEPTH) begin
                model_ovf = 1'b1;
            end else begin
                exp_q.push_back(d);
                model_count++;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset(input logic wo);
        @(negedge clk);
        i_rst   = 1'b1;
        wO      = wo;
        i_data  = WIDTH'($urandom_range(0, 255));
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_rst   = 1'b0;
        wO      = 1'b0;
        i_ready = 1'b0;
        exp_q.delete();
        model_count = 0;
        model_ovf   = 1'b0;
    endtask

    task automatic drain();
        while (model_count > 0) cycle(1'b0, '0, 1'b1);
    endtask

    initial begin
        hrm_word_t w;
        i_rst = 1'b1; wO = 1'b0; i_data = '0; i_ready = 1'b0;
        checks = 0; errors = 0; model_count = 0; model_ovf = 1'b0;
        repeat (2) @(posedge clk);
        do_reset(1'b0);

        // Reset state, then single push becomes visible after one edge
        cycle(1'b1, 8'h2A, 1'b0);
        #1;
        chk("lat_valid", 32'(o_valid), 32'd1);
        chk("lat_data", 32'(o_data), 32'h2A);
        chk("lat_count", 32'(o_count), 32'd1);
        drain();
        cycle(1'b0, '0, 1'b0);

        // Fill to capacity with consumer stalled, then overflow attempt
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(i), 1'b0);
        cycle(1'b1, 8'h55, 1'b0);
        cycle(1'b0, '0, 1'b0);
        drain();
        cycle(1'b0, '0, 1'b0);

        // Steady streaming at count 5 across pointer wrap
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, WIDTH'($urandom_range(0, 255)), 1'b1);
        cycle(1'b0, '0, 1'b0);
        drain();

        // Full with simultaneous push and pop: pop wins, push dropped
        do_reset(1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(8'hA0 + i), 1'b0);
        cycle(1'b1, 8'h99, 1'b1);
        cycle(1'b0, '0, 1'b0);
        drain();

        // Reset while pushing discards everything
        do_reset(1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, WIDTH'(8'h30 + i), 1'b0);
        do_reset(1'b1);
        cycle(1'b0, '0, 1'b0);

        // Empty FIFO with push and ready in the same cycle
        cycle(1'b1, 8'h7F, 1'b1);
        cycle(1'b0, '0, 1'b0);
        drain();

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            w = hrm_word_t'($urandom_range(0, 255));
            cycle(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)));
        end
        drain();
        cycle(1'b0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/outbox.md
OUTBOX -- requirements
Module: outbox

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 5, log2 of entry count (DEPTH = 2**DEPTH_LOG2, 32 by default).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit, reset, synchronous and active-high.
REQ-005 SHALL have port wO, input, 1 bit, push strobe from the control unit in its OUTBOX state.
REQ-006 SHALL have port i_data, input, WIDTH bits, value of register R to enqueue.
REQ-007 SHALL have port outFull, output, 1 bit, high when the FIFO holds DEPTH entries.
REQ-008 SHALL have port o_data, output, WIDTH bits, head entry presented to the consumer.
REQ-009 SHALL have port o_valid, output, 1 bit, high when o_data holds a valid entry.
REQ-010 SHALL have port i_ready, input, 1 bit, consumer accepts o_data when o_valid and i_ready are both high.
REQ-011 SHALL have port o_count, output, DEPTH_LOG2+1 bits, current occupancy.
REQ-012 SHALL have port o_overflow, output, 1 bit, sticky flag recording a push attempted while full.

Function
REQ-013 SHALL push on a rising edge when wO=1 and outFull=0: write i_data at the write pointer, then increment the write pointer modulo DEPTH.
REQ-014 SHALL pop on a rising edge when o_valid=1 and i_ready=1, then increment the read pointer modulo DEPTH.
REQ-015 SHALL drop a push when wO=1 and outFull=1: no pointer or count change; o_overflow set to 1 on the next edge.
REQ-016 SHALL, on simultaneous push and pop with 0<count<DEPTH, perform both and leave o_count unchanged.
REQ-017 SHALL, when full with pop and wO both high in one cycle, perform the pop and drop the push (outFull is evaluated before the edge); o_overflow is set.
REQ-018 SHALL compute o_count = written-minus-read pointer difference using DEPTH_LOG2+1-bit pointers with a wrap bit; full = pointers equal except MSB; empty = pointers equal.
REQ-019 SHALL be show-ahead: o_valid = not empty; o_data = entry at read pointer.
REQ-020 SHALL have push-to-o_valid latency of exactly 1 cycle when empty (push edge N, o_valid high after edge N).
REQ-021 SHALL hold o_data stable while o_valid=1 and i_ready=0.
REQ-022 SHALL derive outFull combinationally from the pointers, so it rises in the cycle after the filling push and falls in the cycle after the freeing pop.
REQ-023 SHALL keep o_data unspecified while o_valid=0, and the consumer SHALL NOT sample it.

Reset
REQ-024 SHALL, on i_rst=1 at a rising edge, clear both pointers, so that o_count=0, o_valid=0, outFull=0, and clear o_overflow to 0; storage contents are not cleared.
REQ-025 SHALL give i_rst priority over a simultaneous push or pop, which is discarded; mid-operation reset loses all entries.

Configuration
REQ-026 SHALL support macro OUTBOX_BYPASS_EN; when defined and the FIFO is empty with wO=1 and i_ready=1, it presents i_data on o_data with o_valid=1 in the same cycle, the consumer takes it, and nothing is stored (count stays 0).
REQ-027 SHALL, when OUTBOX_BYPASS_EN is undefined, never assert o_valid combinationally from wO; the REQ-020 latency applies.

Structure
REQ-028 SHALL take WIDTH default, DEPTH_LOG2 default and the data word type from the shared hrm_pkg package, alongside the opcode constants.
REQ-029 SHALL instantiate storage as sub-module ram_dp_async (one synchronous write port, one asynchronous read port, DEPTH x WIDTH); pointers, flags and count stay in outbox.

Verification
REQ-030 SHALL cover: after reset, wO=1 with i_data=0x2A for one cycle -> next cycle o_valid=1, o_data=0x2A, o_count=1.
REQ-031 SHALL cover: i_ready=0, 32 pushes of 0x00..0x1F -> outFull=1, o_count=32; 33rd push (0x55) -> o_overflow=1, o_count=32; then drain with i_ready=1 -> 0x00..0x1F in order, 0x55 absent.
REQ-032 SHALL cover: count=5 with continuous wO and i_ready for 40 cycles -> o_count stays 5, order preserved across pointer wrap.
REQ-033 SHALL cover: full FIFO with wO=1 and i_ready=1 in the same cycle -> head popped, push dropped, o_count=31, o_overflow=1.
REQ-034 SHALL cover: count=7 and i_rst pulsed while pushing -> next cycle o_count=0, o_valid=0, outFull=0, o_overflow=0.
REQ-035 SHALL cover: with OUTBOX_BYPASS_EN, empty FIFO, wO=1, i_data=0x7F, i_ready=1 -> same-cycle o_valid=1, o_data=0x7F, and o_count=0 after the edge; without the macro -> o_valid=0 that cycle.
